dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder at the far end of the pipeline MEM-stage load/store interface.
//  Accepts one word request at a time and performs the access after LATENCY cycles.
//  Returns ack_o, plus rdata_o for reads, and holds busy_o so the CPU can stall IF..MEM.
//  Contains its own word-addressed storage of 2**ADDR_W x 32 bits.
// PARAMETERS
//  ADDR_W   10  word-index width; storage depth = 2**ADDR_W words
//  LATENCY  2   cycles from request acceptance to the access edge; legal range 1..15
// PORTS
//  clk_i    in   1   clock, rising edge
//  rst_i    in   1   asynchronous, active-low reset
//  req_i    in   1   request valid (MEM_MemRead | MEM_MemWrite)
//  we_i     in   1   1 = store, 0 = load
//  addr_i   in   32  byte address (MEM_ALUresult)
//  wdata_i  in   32  store data (MEM_memwritedata)
//  busy_o   out  1   responder not idle; request will not be accepted
//  ack_o    out  1   one-cycle completion pulse
//  rdata_o  out  32  load data, valid while ack_o=1, held afterwards
//  err_o    out  1   qualifies ack_o: misaligned or out-of-range address
// BEHAVIOUR
//  Reset (rst_i=0, async):
//   - State = IDLE, cnt = 0, ack_o = 0, err_o = 0, rdata_o = 0, latched request fields = 0.
//   - Storage array is not reset.
//   - An in-flight request is aborted: a pending store is dropped and no ack is issued.
//  FSM IDLE -> WAIT -> RESP -> IDLE; busy_o = (state != IDLE), decoded from registered state.
//  IDLE:
//   - On an edge with req_i=1: latch we_i, addr_i, wdata_i; cnt <= LATENCY-1; go to WAIT.
//   - With req_i=0: stay in IDLE.
//  WAIT:
//   - req_i, we_i, addr_i and wdata_i are ignored; they are not queued.
//   - If cnt != 0: cnt <= cnt-1.
//   - If cnt == 0: perform the access; ack_o <= 1; go to RESP.
//  RESP:
//   - ack_o is high for exactly this cycle.
//   - Next edge: ack_o <= 0, err_o <= 0, go to IDLE.
//   - A req_i asserted during RESP is ignored; it is accepted in IDLE only.
//  Latency:
//   - A request accepted at edge t0 produces ack_o=1 in the cycle after edge t0+LATENCY.
//   - Earliest next acceptance is edge t0+LATENCY+2.
//   - With LATENCY=1 the period is 3 cycles per access.
//  Access at the WAIT->RESP edge:
//   - idx = addr[ADDR_W+1:2].
//   - Error if addr[1:0] != 0 or addr[31:ADDR_W+2] != 0.
//     - On error: err_o <= 1, no write, rdata_o <= 0.
//   - Legal store: mem[idx] <= wdata; rdata_o unchanged; err_o <= 0.
//   - Legal load: rdata_o <= mem[idx], reflecting all earlier completed stores; err_o <= 0.
//  rdata_o holds its value until the next load ack or reset.
//  cnt is 4 bits; no wrap occurs because it is loaded only in IDLE and stops at 0.
// TESTING
//  1. Reset held low 3 cycles then released:
//     busy_o=0, ack_o=0, err_o=0, rdata_o=0; req_i=0 for 10 cycles gives no ack.
//  2. LATENCY=2, store addr 0x10 data 0xDEADBEEF at edge t0:
//     busy_o=1 from t0; ack_o=1 only in the cycle after t0+2; err_o=0; busy_o=0 after t0+3.
//  3. Load addr 0x10 after test 2:
//     rdata_o=0xDEADBEEF with ack_o; value held for 5 idle cycles.
//  4. Load addr 0x12 (misaligned), then store to 0x1000 with ADDR_W=10 (out of range):
//     each acks with err_o=1 and rdata_o=0; a later load of 0x0 still returns the prior contents.
//  5. Back-to-back req_i held high with a different addr each cycle:
//     only addrs sampled in IDLE are serviced, one ack per LATENCY+2 cycles.
//  6. Store to 0x20 with rst_i pulsed low mid-WAIT:
//     no ack ever issued; after reset a load of 0x20 returns its pre-store value.

Source files
------------

// File: rtl/dmem_if.sv
// Load/store handshake between the MEM stage and the data-memory responder.
interface dmem_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  busy_o, ack_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output busy_o, ack_o, rdata_o, err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one word access at a time, completed LATENCY cycles
// after acceptance, with a one-cycle ack and a busy flag for pipeline stall.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    dmem_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               we_q, we_n;
    logic [31:0]        addr_q, addr_n;
    logic [31:0]        wdata_q, wdata_n;
    logic               ack_q, ack_n;
    logic               err_q, err_n;
    logic [31:0]        rdata_q, rdata_n;
    logic               busy_q, busy_n;
    logic               mem_we;
    logic [ADDR_W-1:0]  idx;
    logic               addr_err;

    logic [31:0] mem [DEPTH];

    // Word index and address legality of the latched request.
    always_comb begin
        idx      = addr_q[ADDR_W+1:2];
        addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        we_n    = we_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        ack_n   = 1'b0;
        err_n   = err_q;
        rdata_n = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    we_n    = bus.we_i;
                    addr_n  = bus.addr_i;
                    wdata_n = bus.wdata_i;
                    cnt_n   = CNT_W'(LATENCY - 1);
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - CNT_W'(1);
                end else begin
                    ack_n   = 1'b1;
                    state_n = RESP;
                    if (addr_err) begin
                        err_n   = 1'b1;
                        rdata_n = 32'h0;
                    end else begin
                        err_n = 1'b0;
                        if (we_q) begin
                            mem_we = 1'b1;
                        end else begin
                            rdata_n = mem[idx];
                        end
                    end
                end
            end
            RESP: begin
                err_n   = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // Control and response registers; reset aborts any in-flight access.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            ack_q   <= ack_n;
            err_q   <= err_n;
            rdata_q <= rdata_n;
            busy_q  <= busy_n;
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.rdata_o = rdata_q;

endmodule
